// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline inter-stage registers: holding-state
// encoding, the NOP control bundle and the per-stage control widths.
package pipe_pkg;

  // Holding state of a stage register: nothing, main entry, main + skid entry
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Widest control bundle any stage uses; the NOP bundle is sliced from it
  localparam int MAX_CTRL_W = 64;
  localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = {MAX_CTRL_W{1'b0}};

  // Control bundle widths used by the instantiating stages
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_CTRL_W = 4;

  // Number of entries held in a given state
  function automatic logic [1:0] state_occupancy(input pipe_state_e st);
    case (st)
      ST_EMPTY: return 2'd0;
      ST_ONE:   return 2'd1;
      ST_TWO:   return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and
// an optional 2-entry skid buffer that registers in_ready. Bubbles always
// carry an all-zero control bundle so downstream stages see a NOP.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [CTRL_W-1:0] L_NOP = NOP_CTRL[CTRL_W-1:0];

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e       r_state;
      logic [CTRL_W-1:0] r_main_ctrl;
      logic [DATA_W-1:0] r_main_data;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              r_in_ready;
      logic              r_out_valid;
      logic [1:0]        r_occ;

      // Holding FSM: main entry drives the outputs, skid catches the beat
      // accepted during the cycle a stall begins; all outputs registered.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state     <= ST_EMPTY;
          r_main_ctrl <= L_NOP;
          r_main_data <= {DATA_W{1'b0}};
          r_skid_ctrl <= L_NOP;
          r_skid_data <= {DATA_W{1'b0}};
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occ       <= 2'd0;
        end else if (flush) begin
          // Data is left in place; only the control bundle becomes a NOP
          r_state     <= ST_EMPTY;
          r_main_ctrl <= L_NOP;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occ       <= 2'd0;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (in_valid) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
                r_state     <= ST_ONE;
                r_out_valid <= 1'b1;
                r_occ       <= state_occupancy(ST_ONE);
              end else begin
                r_state <= ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (in_valid && out_ready) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
                r_state     <= ST_ONE;
              end else if (in_valid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
                r_state     <= ST_TWO;
                r_in_ready  <= 1'b0;
                r_occ       <= state_occupancy(ST_TWO);
              end else if (out_ready) begin
                r_main_ctrl <= L_NOP;
                r_state     <= ST_EMPTY;
                r_out_valid <= 1'b0;
                r_occ       <= state_occupancy(ST_EMPTY);
              end else begin
                r_state <= ST_ONE;
              end
            end
            ST_TWO: begin
              if (out_ready) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
                r_state     <= ST_ONE;
                r_in_ready  <= 1'b1;
                r_occ       <= state_occupancy(ST_ONE);
              end else begin
                r_state <= ST_TWO;
              end
            end
            default: begin
              r_state     <= ST_EMPTY;
              r_main_ctrl <= L_NOP;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_occ       <= 2'd0;
            end
          endcase
        end
      end

      assign in_ready  = r_in_ready;
      assign out_valid = r_out_valid;
      assign out_ctrl  = r_main_ctrl;
      assign out_data  = r_main_data;
      assign occupancy = r_occ;
    end else begin : g_single
      logic              r_valid;
      logic [CTRL_W-1:0] r_ctrl;
      logic [DATA_W-1:0] r_data;
      logic              w_in_ready;

      // Single gate level from out_ready to in_ready
      assign w_in_ready = ~r_valid | out_ready;

      // Single-entry register: load on accept, empty when drained without refill
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_ctrl  <= L_NOP;
          r_data  <= {DATA_W{1'b0}};
        end else if (flush) begin
          r_valid <= 1'b0;
          r_ctrl  <= L_NOP;
        end else if (in_valid && w_in_ready) begin
          r_valid <= 1'b1;
          r_ctrl  <= in_ctrl;
          r_data  <= in_data;
        end else if (out_ready) begin
          r_valid <= 1'b0;
          r_ctrl  <= L_NOP;
        end else begin
          r_valid <= r_valid;
        end
      end

      assign in_ready  = w_in_ready;
      assign out_valid = r_valid;
      assign out_ctrl  = r_ctrl;
      assign out_data  = r_data;
      assign occupancy = {1'b0, r_valid};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share the same
// stimulus; a queue-based model of each stage predicts every output.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  // index 1 = SKID=1 instance, index 0 = SKID=0 instance
  logic        d_in_ready [2];
  logic        d_out_valid[2];
  logic [7:0]  d_out_ctrl [2];
  logic [31:0] d_out_data [2];
  logic [1:0]  d_occ      [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  beat_t       q[2][$];
  logic [31:0] last_d[2];

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready[1]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d_out_valid[1]), .out_ready(out_ready),
    .out_ctrl(d_out_ctrl[1]), .out_data(d_out_data[1]),
    .occupancy(d_occ[1])
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(0)) u_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready[0]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d_out_valid[0]), .out_ready(out_ready),
    .out_ctrl(d_out_ctrl[0]), .out_data(d_out_data[0]),
    .occupancy(d_occ[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a stage is a FIFO of at most 2 (SKID=1) or 1 (SKID=0) beats
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit    rdy;
      bit    acc;
      bit    pop;
      beat_t b;
      rdy = (k == 1) ? (q[k].size() < 2) : ((q[k].size() == 0) || out_ready);
      acc = in_valid && rdy;
      pop = (q[k].size() > 0) && out_ready;
      b.c = in_ctrl;
      b.d = in_data;
      if (reset) begin
        q[k].delete();
        last_d[k] = 32'd0;
      end else if (flush) begin
        q[k].delete();
      end else begin
        if (pop) void'(q[k].pop_front());
        if (acc) q[k].push_back(b);
        if (q[k].size() > 0) last_d[k] = q[k][0].d;
      end
    end
  end

  // Compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic       ev;
        logic [7:0] ec;
        logic       er;
        ev = q[k].size() > 0;
        ec = ev ? q[k][0].c : 8'd0;
        er = (k == 1) ? (q[k].size() < 2) : (!ev || out_ready);
        chk($sformatf("skid%0d out_valid", k), {31'd0, d_out_valid[k]}, {31'd0, ev});
        chk($sformatf("skid%0d out_ctrl", k), {24'd0, d_out_ctrl[k]}, {24'd0, ec});
        chk($sformatf("skid%0d out_data", k), d_out_data[k], last_d[k]);
        chk($sformatf("skid%0d occupancy", k), {30'd0, d_occ[k]}, q[k].size());
        chk($sformatf("skid%0d in_ready", k), {31'd0, d_in_ready[k]}, {31'd0, er});
      end
    end
  end

  // One clock; inputs may be changed and outputs read on return
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_ctrl = 8'd0; in_data = 32'd0; out_ready = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    chk("reset in_ready", {31'd0, d_in_ready[1]}, 32'd1);
    chk("reset occupancy", {30'd0, d_occ[1]}, 32'd0);
    chk("reset out_valid", {31'd0, d_out_valid[1]}, 32'd0);
    chk("reset out_data", d_out_data[1], 32'd0);
    reset = 1'b0;

    // Stall with two beats
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 32'h11;
    step();
    chk("single stall in_ready", {31'd0, d_in_ready[0]}, 32'd0);
    in_ctrl = 8'hA2; in_data = 32'h22;
    step();
    chk("stall occupancy", {30'd0, d_occ[1]}, 32'd2);
    chk("stall in_ready", {31'd0, d_in_ready[1]}, 32'd0);
    chk("stall out_data", d_out_data[1], 32'h11);
    chk("stall out_ctrl", {24'd0, d_out_ctrl[1]}, 32'hA1);
    in_valid = 1'b0;
    step();
    chk("stall hold data", d_out_data[1], 32'h11);
    out_ready = 1'b1;
    step();
    chk("drain B data", d_out_data[1], 32'h22);
    chk("drain in_ready", {31'd0, d_in_ready[1]}, 32'd1);
    step();
    chk("drained out_valid", {31'd0, d_out_valid[1]}, 32'd0);
    chk("drained out_ctrl", {24'd0, d_out_ctrl[1]}, 32'd0);

    // Flush in the same cycle a beat is handshaken
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hB4; in_data = 32'h44;
    step();
    in_ctrl = 8'hC3; in_data = 32'h33; flush = 1'b1;
    step();
    chk("flush out_valid", {31'd0, d_out_valid[1]}, 32'd0);
    chk("flush out_ctrl", {24'd0, d_out_ctrl[1]}, 32'd0);
    chk("flush occupancy", {30'd0, d_occ[1]}, 32'd0);
    chk("flush keeps data", d_out_data[1], 32'h44);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flushed C absent", {31'd0, d_out_valid[1]}, 32'd0);

    // Reset while holding two beats
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66; in_data = 32'h66;
    step();
    in_ctrl = 8'h77; in_data = 32'h77;
    step();
    chk("pre-reset occupancy", {30'd0, d_occ[1]}, 32'd2);
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset out_valid", {31'd0, d_out_valid[1]}, 32'd0);
    chk("midreset out_ctrl", {24'd0, d_out_ctrl[1]}, 32'd0);
    chk("midreset occupancy", {30'd0, d_occ[1]}, 32'd0);
    chk("midreset in_ready", {31'd0, d_in_ready[1]}, 32'd1);

    // Back-to-back streaming, one beat per cycle, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = i; in_ctrl = 8'(i + 1);
      step();
      chk($sformatf("stream%0d skid1 data", i), d_out_data[1], i);
      chk($sformatf("stream%0d skid1 valid", i), {31'd0, d_out_valid[1]}, 32'd1);
      chk($sformatf("stream%0d skid0 data", i), d_out_data[0], i);
    end
    in_valid = 1'b0;
    step();

    // Random valid/ready/flush traffic
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (n % 200 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
